// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = $clog2(NUM_VEC);

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter: counts 0..DWELL-1 and wraps, or is held at zero by clr.
module dwell_timer #(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks all eight {a,b,c} vectors through a downstream 3-input block, captures x/y
// into truth tables and compares them against the expected tables.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int         DWELL = 10,
    parameter logic [7:0] EXP_X = 8'h00,
    parameter logic [7:0] EXP_Y = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               a,
    output logic               b,
    output logic               c,
    input  logic               x,
    input  logic               y,
    output logic               busy,
    output logic               done,
    output logic [NUM_VEC-1:0] tt_x,
    output logic [NUM_VEC-1:0] tt_y,
    output logic               pass,
    output logic [1:0]         fsm_state
);

    state_e             state;
    logic [VEC_W-1:0]   idx;
    logic               tick;
    logic [NUM_VEC-1:0] tt_x_cap;
    logic [NUM_VEC-1:0] tt_y_cap;

    assign fsm_state = state;

    // Timer only runs during RUN, so the accepting edge always leaves it at zero.
    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != RUN),
        .tick (tick)
    );

    // Tables as they will look after capturing the current vector.
    always_comb begin
        tt_x_cap      = tt_x;
        tt_y_cap      = tt_y;
        tt_x_cap[idx] = x;
        tt_y_cap[idx] = y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            {a, b, c} <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt_x      <= '0;
            tt_y      <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        idx       <= '0;
                        {a, b, c} <= 3'b000;
                        busy      <= 1'b1;
                        tt_x      <= '0;
                        tt_y      <= '0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        tt_x <= tt_x_cap;
                        tt_y <= tt_y_cap;
                        if (idx == VEC_W'(NUM_VEC - 1)) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            {a, b, c} <= 3'b000;
                            // Compare the tables including the vector captured on this edge.
                            pass      <= (tt_x_cap == EXP_X) && (tt_y_cap == EXP_Y);
                        end else begin
                            idx       <= idx + VEC_W'(1);
                            {a, b, c} <= idx + VEC_W'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized scoreboard bench for tt_sweep_ctrl: one instance with DWELL=10, one with DWELL=1.
module tb_tt_sweep_ctrl;
    import tt_sweep_pkg::*;

    localparam logic [7:0] EXP_X = 8'hC0;
    localparam logic [7:0] EXP_Y = 8'h96;
    localparam int DW0 = 10;
    localparam int DW1 = 1;

    typedef struct packed {
        logic [0:0]  dut;
        logic [31:0] done_at;
        logic [7:0]  tx;
        logic [7:0]  ty;
        logic        ps;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start_s [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       c_s     [2];
    logic       x_s     [2];
    logic       y_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [7:0] tt_x_s  [2];
    logic [7:0] tt_y_s  [2];
    logic       pass_s  [2];
    logic [1:0] fsm_s   [2];

    // bench-side state of the reference model
    bit   yzero     [2];
    bit   sweep_yz  [2];
    bit   active    [2];
    int   start_cyc [2];
    int   next_ok   [2];
    int   dw        [2];
    int   cyc;
    exp_t exp_q[$];
    int   done_edges0[$];

    int n_cmp;
    int n_bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs and downstream logic ----------------
    tt_sweep_ctrl #(.DWELL(DW0), .EXP_X(EXP_X), .EXP_Y(EXP_Y)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .x(x_s[0]), .y(y_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .tt_x(tt_x_s[0]), .tt_y(tt_y_s[0]),
        .pass(pass_s[0]), .fsm_state(fsm_s[0])
    );

    tt_sweep_ctrl #(.DWELL(DW1), .EXP_X(EXP_X), .EXP_Y(EXP_Y)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .x(x_s[1]), .y(y_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .tt_x(tt_x_s[1]), .tt_y(tt_y_s[1]),
        .pass(pass_s[1]), .fsm_state(fsm_s[1])
    );

    assign x_s[0] = a_s[0] & b_s[0];
    assign y_s[0] = yzero[0] ? 1'b0 : (a_s[0] ^ b_s[0] ^ c_s[0]);
    assign x_s[1] = a_s[1] & b_s[1];
    assign y_s[1] = yzero[1] ? 1'b0 : (a_s[1] ^ b_s[1] ^ c_s[1]);

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_tables(bit yz);
        logic [7:0] tx;
        logic [7:0] ty;
        for (int k = 0; k < 8; k++) begin
            int av = (k >> 2) & 1;
            int bv = (k >> 1) & 1;
            int cv = k & 1;
            tx[k] = ((av & bv) != 0);
            ty[k] = yz ? 1'b0 : (((av + bv + cv) % 2) != 0);
        end
        return {tx, ty};
    endfunction

    function automatic logic [23:0] model_obs(int i);
        int         d;
        int         dl;
        logic [15:0] full;
        logic [7:0] tx;
        logic [7:0] ty;
        logic [2:0] v;
        logic       bz;
        logic       dn;
        logic       ps;
        logic [1:0] st;
        if (rst || !active[i]) return {2'(IDLE), 22'd0};
        dl   = dw[i];
        d    = cyc - start_cyc[i];
        full = ref_tables(sweep_yz[i]);
        v    = (d < 8 * dl) ? 3'(d / dl) : 3'd0;
        bz   = (d < 8 * dl);
        dn   = (d == 8 * dl);
        tx   = '0;
        ty   = '0;
        for (int k = 0; k < 8; k++) begin
            if (d >= (k + 1) * dl) begin
                tx[k] = full[8 + k];
                ty[k] = full[k];
            end
        end
        ps = (d >= 8 * dl) && (full == {EXP_X, EXP_Y});
        st = bz ? 2'(RUN) : (dn ? 2'(DONE) : 2'(IDLE));
        return {st, v, bz, dn, tx, ty, ps};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                active[i]  = 1'b0;
                next_ok[i] = 0;
            end
            exp_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start_s[i] && cyc >= next_ok[i]) begin
                    logic [15:0] full;
                    exp_t        rec;
                    full         = ref_tables(yzero[i]);
                    active[i]    = 1'b1;
                    sweep_yz[i]  = yzero[i];
                    start_cyc[i] = cyc;
                    next_ok[i]   = cyc + 8 * dw[i] + 2;
                    rec.dut      = 1'(i);
                    rec.done_at  = 32'(cyc + 8 * dw[i]);
                    rec.tx       = full[15:8];
                    rec.ty       = full[7:0];
                    rec.ps       = (full == {EXP_X, EXP_Y});
                    exp_q.push_back(rec);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] act;
        exp_t        rec;
        exp_t        got;
        for (int i = 0; i < 2; i++) begin
            act = {fsm_s[i], a_s[i], b_s[i], c_s[i], busy_s[i], done_s[i],
                   tt_x_s[i], tt_y_s[i], pass_s[i]};
            check($sformatf("obs_dut%0d", i), 64'(act), 64'(model_obs(i)));
            if (done_s[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("done_unexpected_dut%0d", i), 64'd1, 64'd0);
                end else begin
                    rec         = exp_q.pop_front();
                    got.dut     = 1'(i);
                    got.done_at = 32'(cyc);
                    got.tx      = tt_x_s[i];
                    got.ty      = tt_y_s[i];
                    got.ps      = pass_s[i];
                    check($sformatf("done_rec_dut%0d", i), 64'(got), 64'(rec));
                    if (i == 0) done_edges0.push_back(cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input int i, input bit yz);
        @(negedge clk);
        yzero[i]   = yz;
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic wait_drain(input int i, input bit noise);
        for (int n = 0; n < 8 * dw[i] + 20 && exp_q.size() != 0; n++) begin
            if (noise && (cyc + 1 < next_ok[i]) && $urandom_range(0, 3) == 0)
                start_s[i] = 1'b1;
            else
                start_s[i] = 1'b0;
            @(negedge clk);
        end
        start_s[i] = 1'b0;
        check($sformatf("drain_timeout_dut%0d", i), 64'(exp_q.size()), 64'd0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        dw[0] = DW0;
        dw[1] = DW1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            yzero[i]   = 1'b0;
            active[i]  = 1'b0;
            next_ok[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // start raised together with reset release: first edge must accept it
        rst        = 1'b0;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_drain(0, 1'b0);

        // forced-zero y and random sweeps with stray start pulses
        issue_start(0, 1'b1);
        wait_drain(0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            issue_start(0, 1'($urandom_range(0, 1)));
            wait_drain(0, 1'b1);
        end

        // start held high: three back-to-back sweeps
        done_edges0.delete();
        yzero[0]   = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b1;
        for (int n = 0; n < 3 * (8 * DW0 + 2) + 20 && done_edges0.size() < 3; n++)
            @(negedge clk);
        start_s[0] = 1'b0;
        check("held_done_count", 64'(done_edges0.size()), 64'd3);
        if (done_edges0.size() == 3) begin
            check("held_gap1", 64'(done_edges0[1] - done_edges0[0]), 64'(8 * DW0 + 2));
            check("held_gap2", 64'(done_edges0[2] - done_edges0[1]), 64'(8 * DW0 + 2));
        end
        wait_drain(0, 1'b0);

        // asynchronous reset while vector 3 is on the bus
        issue_start(0, 1'b0);
        for (int n = 0; n < 100 && (cyc - start_cyc[0]) < 3 * DW0 + 4; n++)
            @(negedge clk);
        check("pre_reset_vector", 64'({a_s[0], b_s[0], c_s[0]}), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({a_s[0], b_s[0], c_s[0], busy_s[0], done_s[0], tt_x_s[0], tt_y_s[0], pass_s[0]}),
              64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue_start(0, 1'b0);
        wait_drain(0, 1'b0);

        // DWELL=1 instance: one vector per cycle
        for (int s = 0; s < 6; s++) begin
            issue_start(1, (s == 1) ? 1'b1 : ((s == 0) ? 1'b0 : 1'($urandom_range(0, 1))));
            wait_drain(1, 1'b1);
        end

        repeat (3) @(negedge clk);
        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
